qed_trace_reader: RTL and testbench
===================================

// Module: qed_trace_reader
// PURPOSE
//  Read-out side of the QED trace recorder. Once the recorder freezes on a fault, this block walks both
//  frozen MEM_WB_PACKET trace buffers oldest-to-newest. It emits one (pkt1, pkt2) pair per beat over a
//  valid/ready stream and flags per-beat divergence plus the first diverging entry.
//  Sits beside the recorder, feeding the debug/dump path.
// PARAMETERS
//  FIFO_SIZE   16   Depth of each trace buffer; must match the recorder (power of 2, >=2).
//  IW          $clog2(FIFO_SIZE)   Index width (localparam, not overridable).
// PORTS
//  clk                 in   1            Clock, rising edge.
//  reset               in   1            Synchronous, active-low reset (0 = reset).
//  trace1              in   [FIFO_SIZE] MEM_WB_PACKET   Frozen recorder buffer 1.
//  trace2              in   [FIFO_SIZE] MEM_WB_PACKET   Frozen recorder buffer 2.
//  head1, head2        in   IW           Recorder write pointers (next slot to write).
//  has_fault_occured   in   1            Recorder frozen flag; trace contents stable while high.
//  fault_count         in   32 (int)     Recorder count of packets written before freeze.
//  start               in   1            Manual read-out request (1-cycle pulse). Ignored unless IDLE.
//  out_valid           out  1            Beat valid.
//  out_ready           in   1            Consumer accepts beat when out_valid & out_ready.
//  out_idx             out  IW           Buffer slot of this beat.
//  out_pkt1, out_pkt2  out  MEM_WB_PACKET   Beat payload (trace1/trace2 at out_idx).
//  out_mismatch        out  1            out_pkt1 != out_pkt2 (full-packet compare).
//  out_last            out  1            Final beat of this read-out.
//  busy                out  1            High in ARM and STREAM.
//  done                out  1            1-cycle pulse on entry to DONE.
//  mismatch_found      out  1            Sticky: some beat of this read-out mismatched.
//  first_mismatch_seq  out  IW+1         Chronological position (0 = oldest) of first mismatch.
//  head_err            out  1            Sticky: head1 != head2 when read-out was armed.
// BEHAVIOUR
//  Reset (reset==0): state IDLE; every output 0. Applies mid-stream: the beat is dropped, with no done pulse.
//  FSM: IDLE -> ARM -> STREAM -> DONE -> IDLE.
//   IDLE:  go to ARM on rising edge of has_fault_occured (registered compare), or on start while has_fault_occured==1.
//          start with has_fault_occured==0 is ignored.
//   ARM (1 cycle): latch n = min(fault_count, FIFO_SIZE) (saturate; negative treated as 0).
//          Latch rd_ptr = (fault_count >= FIFO_SIZE) ? head1 : 0. Latch head_err = (head1 != head2).
//          Clear mismatch_found and first_mismatch_seq. Zero beats to send (n == 0) -> DONE directly.
//   STREAM: beat k (k = 0..n-1) presents slot (rd_ptr + k) mod FIFO_SIZE. out_pkt1/out_pkt2 are registered.
//          First out_valid appears the cycle after ARM; start-edge to first beat latency is 2 cycles.
//          Payload, out_idx, out_mismatch and out_last are held stable while out_valid & !out_ready.
//          out_valid is never dropped before acceptance.
//          Accept beat: advance pointer with wrap FIFO_SIZE-1 -> 0; next beat valid the following cycle.
//          Sustains 1 beat/cycle with out_ready tied high.
//          out_last = (k == n-1). Accept of the last beat -> DONE.
//          On accepting a mismatching beat when mismatch_found==0: mismatch_found<=1, first_mismatch_seq<=k.
//   DONE:  pulse done for 1 cycle. Hold mismatch_found, first_mismatch_seq and head_err.
//          Stay in DONE until has_fault_occured==0 (recorder reset), then go to IDLE.
//          A start pulse in DONE re-runs the read-out (-> ARM).
//  head_err does not abort the read-out; head1 is the authoritative pointer.
//  If has_fault_occured falls during STREAM, the read-out still completes (data is no longer guaranteed; the bench avoids this).
//  Read-out is non-destructive; the recorder buffers are never written by this block.
// TESTING
//  1 Wrap: FIFO_SIZE=16, fault_count=40, head1=head2=8, slot i holds tag i in both traces.
//    -> 16 beats with out_idx 8..15,0..7; out_last on beat 16; done pulse; mismatch_found=0.
//  2 Partial fill: fault_count=5, head=5.
//    -> 5 beats with out_idx 0..4; out_last on idx 4; beat 1 valid 2 cycles after has_fault_occured rises.
//  3 Divergence: wrapped buffer with head=3; trace2 slot 6 and slot 9 differ.
//    -> out_mismatch on beats 3 and 6; first_mismatch_seq=3; mismatch_found=1 after done.
//  4 Backpressure: out_ready random 30% high.
//    -> payload and out_idx stable while stalled; no beat lost or duplicated; beat count == n.
//  5 Empty/corner: fault_count=0 -> ARM->DONE with no out_valid, done pulse.
//    head1=4, head2=5 -> head_err=1, stream still follows head1.
//  6 Reset mid-stream: reset=0 at beat 7 -> next cycle all outputs 0, IDLE.
//    Re-arm via start -> full read-out from beat 0.

Source files
------------

// File: rtl/qed_trace_reader.sv
// QED trace reader: walks both frozen recorder buffers oldest-to-newest and
// streams (pkt1, pkt2) pairs with per-beat divergence and first-divergence tracking.

package qed_trace_pkg;

    // One MEM/WB stage record as captured by the trace recorder.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_we;
        logic        valid;
    } mem_wb_packet_t;

endpackage

module qed_trace_reader
    import qed_trace_pkg::*;
#(
    parameter  int unsigned FIFO_SIZE = 16,
    localparam int unsigned IW        = $clog2(FIFO_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  mem_wb_packet_t        trace1 [FIFO_SIZE],
    input  mem_wb_packet_t        trace2 [FIFO_SIZE],
    input  logic [IW-1:0]         head1,
    input  logic [IW-1:0]         head2,
    input  logic                  has_fault_occured,
    input  logic signed [31:0]    fault_count,
    input  logic                  start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IW-1:0]         out_idx,
    output mem_wb_packet_t        out_pkt1,
    output mem_wb_packet_t        out_pkt2,
    output logic                  out_mismatch,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch_found,
    output logic [IW:0]           first_mismatch_seq,
    output logic                  head_err
);

    localparam int unsigned       CW   = IW + 1;
    localparam logic signed [31:0] FS_S = $signed(32'(FIFO_SIZE));

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            fault_q;
    logic [CW-1:0]   n_q, n_d;
    logic [CW-1:0]   k_q, k_d;
    logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            valid_q, valid_d;
    mem_wb_packet_t  pkt1_q, pkt1_d;
    mem_wb_packet_t  pkt2_q, pkt2_d;
    logic            mism_q, mism_d;
    logic            last_q, last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            mf_q, mf_d;
    logic [CW-1:0]   fms_q, fms_d;
    logic            herr_q, herr_d;

    logic [CW-1:0]   arm_n;
    logic [IW-1:0]   arm_ptr;
    logic            ld_en;
    logic [IW-1:0]   ld_ptr;
    logic            fault_rise;

    assign fault_rise = has_fault_occured & ~fault_q;

    // Beat count (saturated, negative -> 0) and oldest slot for a new read-out.
    always_comb begin
        arm_n   = '0;
        arm_ptr = '0;
        if (fault_count <= 32'sd0) begin
            arm_n = '0;
        end else if (fault_count >= FS_S) begin
            arm_n = CW'(FIFO_SIZE);
        end else begin
            arm_n = CW'(fault_count);
        end
        if (fault_count >= FS_S) begin
            arm_ptr = head1;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        k_d      = k_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        pkt1_d   = pkt1_q;
        pkt2_d   = pkt2_q;
        mism_d   = mism_q;
        last_d   = last_q;
        done_d   = 1'b0;
        mf_d     = mf_q;
        fms_d    = fms_q;
        herr_d   = herr_q;
        ld_en    = 1'b0;
        ld_ptr   = rd_ptr_q;

        case (state_q)
            ST_IDLE: begin
                if (fault_rise || (start && has_fault_occured)) begin
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                n_d      = arm_n;
                k_d      = '0;
                rd_ptr_d = arm_ptr;
                herr_d   = (head1 != head2);
                mf_d     = 1'b0;
                fms_d    = '0;
                if (arm_n == '0) begin
                    state_d = ST_DONE;
                    valid_d = 1'b0;
                    mism_d  = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STREAM;
                    valid_d = 1'b1;
                    ld_en   = 1'b1;
                    ld_ptr  = arm_ptr;
                    last_d  = (arm_n == CW'(1));
                end
            end

            ST_STREAM: begin
                if (valid_q && out_ready) begin
                    if (mism_q && !mf_q) begin
                        mf_d  = 1'b1;
                        fms_d = k_q;
                    end
                    if (last_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        mism_d  = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d      = k_q + CW'(1);
                        rd_ptr_d = rd_ptr_q + IW'(1);
                        ld_en    = 1'b1;
                        ld_ptr   = rd_ptr_q + IW'(1);
                        last_d   = ((k_q + CW'(1)) == (n_q - CW'(1)));
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_d = ST_ARM;
                end else if (!has_fault_occured) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (ld_en) begin
            pkt1_d = trace1[ld_ptr];
            pkt2_d = trace2[ld_ptr];
            mism_d = (trace1[ld_ptr] != trace2[ld_ptr]);
        end

        busy_d = (state_d == ST_ARM) || (state_d == ST_STREAM);
    end

    // State and output registers; fault_q keeps tracking the recorder during reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            fault_q  <= has_fault_occured;
            n_q      <= '0;
            k_q      <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            pkt1_q   <= '0;
            pkt2_q   <= '0;
            mism_q   <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mf_q     <= 1'b0;
            fms_q    <= '0;
            herr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fault_q  <= has_fault_occured;
            n_q      <= n_d;
            k_q      <= k_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            pkt1_q   <= pkt1_d;
            pkt2_q   <= pkt2_d;
            mism_q   <= mism_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mf_q     <= mf_d;
            fms_q    <= fms_d;
            herr_q   <= herr_d;
        end
    end

    assign out_valid          = valid_q;
    assign out_idx            = rd_ptr_q;
    assign out_pkt1           = pkt1_q;
    assign out_pkt2           = pkt2_q;
    assign out_mismatch       = mism_q;
    assign out_last           = last_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign mismatch_found     = mf_q;
    assign first_mismatch_seq = fms_q;
    assign head_err           = herr_q;

endmodule

// File: tb/tb_qed_trace_reader.sv
// Directed bench for qed_trace_reader: vector table of read-out scenarios plus
// hand-written reset, start-gating and re-run sequences.

module tb_qed_trace_reader;
    import qed_trace_pkg::*;

    localparam int FS = 16;

    logic               clk = 1'b0;
    logic               reset;
    mem_wb_packet_t     tr1 [FS];
    mem_wb_packet_t     tr2 [FS];
    logic [3:0]         head1, head2;
    logic               has_fault;
    logic signed [31:0] fault_count;
    logic               start;
    logic               out_ready;
    logic               out_valid;
    logic [3:0]         out_idx;
    mem_wb_packet_t     out_pkt1, out_pkt2;
    logic               out_mismatch, out_last, busy, done, mismatch_found, head_err;
    logic [4:0]         first_mismatch_seq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          fc;
        logic [3:0]  h1;
        logic [3:0]  h2;
        logic [15:0] mask;
        int          rdy;
        int          n;
        logic [3:0]  st;
        logic        he;
        logic        mf;
        int          fms;
    } vec_t;

    vec_t vecs [9];

    qed_trace_reader #(.FIFO_SIZE(FS)) dut (
        .clk                (clk),
        .reset              (reset),
        .trace1             (tr1),
        .trace2             (tr2),
        .head1              (head1),
        .head2              (head2),
        .has_fault_occured  (has_fault),
        .fault_count        (fault_count),
        .start              (start),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_idx            (out_idx),
        .out_pkt1           (out_pkt1),
        .out_pkt2           (out_pkt2),
        .out_mismatch       (out_mismatch),
        .out_last           (out_last),
        .busy               (busy),
        .done               (done),
        .mismatch_found     (mismatch_found),
        .first_mismatch_seq (first_mismatch_seq),
        .head_err           (head_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mem_wb_packet_t mk_pkt(input int i);
        mem_wb_packet_t p;
        p.pc     = 32'h0000_1000 + 32'(i * 4);
        p.result = 32'hA500_0000 | 32'(i);
        p.rd     = 5'(i);
        p.reg_we = ((i % 2) == 1);
        p.valid  = 1'b1;
        return p;
    endfunction

    task automatic load_cfg(input vec_t v);
        for (int i = 0; i < FS; i++) begin
            tr1[i] = mk_pkt(i);
            tr2[i] = mk_pkt(i);
            if (v.mask[i]) tr2[i].result = tr2[i].result ^ 32'h00FF_0000;
        end
        head1       = v.h1;
        head2       = v.h2;
        fault_count = 32'(v.fc);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_pkt1"}, out_pkt1, 0);
        chk({tag, "_pkt2"}, out_pkt2, 0);
        chk({tag, "_mism"}, out_mismatch, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mf"}, mismatch_found, 0);
        chk({tag, "_fms"}, first_mismatch_seq, 0);
        chk({tag, "_herr"}, head_err, 0);
    endtask

    // One complete read-out, triggered by a fault rising edge or by a start pulse.
    task automatic run_case(input int id, input vec_t v, input bit via_start);
        int         k = 0;
        int         cyc = 0;
        int         first_valid = -1;
        int         done_cyc = -1;
        int         extra = 0;
        bit         got_done = 1'b0;
        logic [3:0] ei;
        string      tg;

        if (!via_start) begin
            @(negedge clk);
            has_fault = 1'b0;
            @(negedge clk);
            @(negedge clk);
            load_cfg(v);
            @(negedge clk);
            has_fault = 1'b1;
        end else begin
            load_cfg(v);
            @(negedge clk);
            start = 1'b1;
        end

        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            tg = $sformatf("v%0d_k%0d", id, k);
            if (cyc == 1) chk({tg, "_arm_busy"}, busy, 1);
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (k >= v.n) begin
                    extra++;
                end else begin
                    ei = 4'(v.st + 4'(k));
                    chk({tg, "_idx"}, out_idx, ei);
                    chk({tg, "_pkt1"}, out_pkt1, tr1[ei]);
                    chk({tg, "_pkt2"}, out_pkt2, tr2[ei]);
                    chk({tg, "_mism"}, out_mismatch, v.mask[ei]);
                    chk({tg, "_last"}, out_last, (k == v.n - 1));
                    chk({tg, "_busy"}, busy, 1);
                end
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                chk({tg, "_beats_at_done"}, k, v.n);
                chk({tg, "_mf"}, mismatch_found, v.mf);
                chk({tg, "_fms"}, first_mismatch_seq, 5'(v.fms));
                chk({tg, "_herr"}, head_err, v.he);
            end
            out_ready = ($urandom_range(99) < v.rdy);
            if (out_valid && out_ready) k++;
        end

        tg = $sformatf("v%0d", id);
        chk({tg, "_done_seen"}, got_done, 1);
        chk({tg, "_extra_beats"}, extra, 0);
        if (v.n > 0) chk({tg, "_first_valid_lat"}, first_valid, 2);
        else         chk({tg, "_empty_done_lat"}, done_cyc, 2);
        @(negedge clk);
        chk({tg, "_done_pulse_end"}, done, 0);
        chk({tg, "_post_valid"}, out_valid, 0);
        chk({tg, "_post_busy"}, busy, 0);
        chk({tg, "_post_mf_hold"}, mismatch_found, v.mf);
        out_ready = 1'b1;
    endtask

    initial begin
        vec_t vr;
        int   k;

        //        fc  h1     h2     mask      rdy  n   st     he    mf    fms
        vecs[0] = '{40, 4'd8,  4'd8,  16'h0000, 100, 16, 4'd8,  1'b0, 1'b0, 0};
        vecs[1] = '{5,  4'd5,  4'd5,  16'h0000, 100, 5,  4'd0,  1'b0, 1'b0, 0};
        vecs[2] = '{20, 4'd3,  4'd3,  16'h0240, 100, 16, 4'd3,  1'b0, 1'b1, 3};
        vecs[3] = '{33, 4'd11, 4'd11, 16'h0001, 30,  16, 4'd11, 1'b0, 1'b1, 5};
        vecs[4] = '{0,  4'd0,  4'd0,  16'h0000, 100, 0,  4'd0,  1'b0, 1'b0, 0};
        vecs[5] = '{-3, 4'd7,  4'd7,  16'hFFFF, 100, 0,  4'd0,  1'b0, 1'b0, 0};
        vecs[6] = '{17, 4'd4,  4'd5,  16'h0010, 60,  16, 4'd4,  1'b1, 1'b1, 0};
        vecs[7] = '{1,  4'd1,  4'd1,  16'h0001, 50,  1,  4'd0,  1'b0, 1'b1, 0};
        vecs[8] = '{15, 4'd15, 4'd15, 16'h4000, 100, 15, 4'd0,  1'b0, 1'b1, 14};

        reset     = 1'b0;
        has_fault = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        load_cfg(vecs[0]);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        // Start without a frozen recorder must be ignored.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("start_ign_busy%0d", i), busy, 0);
            chk($sformatf("start_ign_valid%0d", i), out_valid, 0);
        end

        for (int i = 0; i < 9; i++) run_case(i, vecs[i], 1'b0);

        // Start pulse while in DONE re-runs the same read-out.
        run_case(9, vecs[8], 1'b1);

        // Reset at beat 7 of a wrapped read-out, then re-arm with start.
        vr = '{40, 4'd8, 4'd9, 16'h0200, 100, 16, 4'd8, 1'b1, 1'b1, 1};
        @(negedge clk);
        has_fault = 1'b0;
        @(negedge clk);
        @(negedge clk);
        load_cfg(vr);
        out_ready = 1'b1;
        @(negedge clk);
        has_fault = 1'b1;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (k == 7) break;
                k++;
            end
        end
        chk("rst_mid_reached_beat7", k, 7);
        chk("rst_mid_pre_mf", mismatch_found, 1);
        chk("rst_mid_pre_herr", head_err, 1);
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_mid");
        reset = 1'b1;
        @(negedge clk);
        run_case(10, vr, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
